// File: rtl/fpu_arb_ctrl.sv
// Two-requester round-robin front end for a shared combinational FP ALU.
// One operation in flight: operands are held on the ALU for ISSUE_WAIT cycles, then the response is registered.
module fpu_arb_ctrl #(
  parameter int ISSUE_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [5:0]  req0_func,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [5:0]  req1_func,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic [31:0] resp0_result,
  output logic        resp0_cond,
  output logic        resp0_err,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [31:0] resp1_result,
  output logic        resp1_cond,
  output logic        resp1_err,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [5:0]  alu_func,
  input  logic [31:0] alu_result,
  input  logic        alu_eq,
  input  logic        alu_lt,
  input  logic        alu_gt,
  input  logic        alu_le,
  input  logic        alu_ge,
  output logic        fcc
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

  localparam logic [3:0] CNT_LAST = 4'(ISSUE_WAIT - 1);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        id_q, id_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        fcc_q, fcc_d;
  logic [31:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [5:0]  func_q, func_d;
  logic        cond_q, cond_d, err_q, err_d;
  logic        gnt_id, accept, resp_hs, cap_cond;

  function automatic logic sel_cond(input logic [5:0] f, input logic eq, input logic lt,
                                    input logic le, input logic gt, input logic ge);
    logic c;
    case (f)
      6'd2:    c = eq;
      6'd3:    c = lt;
      6'd4:    c = le;
      6'd5:    c = gt;
      6'd6:    c = ge;
      default: c = 1'b0;
    endcase
    sel_cond = c;
  endfunction

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    gnt_id = 1'b0;
    if (req0_valid && req1_valid) gnt_id = ~last_q;
    else if (req1_valid)          gnt_id = 1'b1;
  end

  assign accept     = !rst && (state_q == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !gnt_id;
  assign req1_ready = accept && gnt_id;
  assign resp_hs    = (state_q == RESP) && (id_q ? resp1_ready : resp0_ready);
  assign cap_cond   = sel_cond(func_q, alu_eq, alu_lt, alu_le, alu_gt, alu_ge);

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    id_d     = id_q;
    cnt_d    = cnt_q;
    fcc_d    = fcc_q;
    a_d      = a_q;
    b_d      = b_q;
    func_d   = func_q;
    result_d = result_q;
    cond_d   = cond_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ISSUE;
          last_d  = gnt_id;
          id_d    = gnt_id;
          cnt_d   = '0;
          a_d     = gnt_id ? req1_a    : req0_a;
          b_d     = gnt_id ? req1_b    : req0_b;
          func_d  = gnt_id ? req1_func : req0_func;
        end
      end
      ISSUE: begin
        if (cnt_q == CNT_LAST) begin
          state_d  = RESP;
          result_d = '0;
          cond_d   = 1'b0;
          err_d    = 1'b0;
          if (func_q inside {6'd0, 6'd1, 6'd7}) begin
            result_d = alu_result;
          end else if (func_q <= 6'd6) begin
            cond_d = cap_cond;
            fcc_d  = cap_cond;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        if (resp_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: cleared immediately by reset; last_q=1 lets req0 win the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      cnt_q   <= '0;
      fcc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      fcc_q   <= fcc_d;
    end
  end

  // Datapath holding registers; only visible through state-qualified outputs.
  always_ff @(posedge clk) begin
    a_q      <= a_d;
    b_q      <= b_d;
    func_q   <= func_d;
    result_q <= result_d;
    cond_q   <= cond_d;
    err_q    <= err_d;
  end

  assign alu_a    = (state_q == ISSUE) ? a_q    : '0;
  assign alu_b    = (state_q == ISSUE) ? b_q    : '0;
  assign alu_func = (state_q == ISSUE) ? func_q : '0;

  assign resp0_valid  = (state_q == RESP) && !id_q;
  assign resp1_valid  = (state_q == RESP) && id_q;
  assign resp0_result = resp0_valid ? result_q : '0;
  assign resp0_cond   = resp0_valid && cond_q;
  assign resp0_err    = resp0_valid && err_q;
  assign resp1_result = resp1_valid ? result_q : '0;
  assign resp1_cond   = resp1_valid && cond_q;
  assign resp1_err    = resp1_valid && err_q;
  assign fcc          = fcc_q;

endmodule

// File: tb/tb_fpu_arb_ctrl.sv
// Bench for fpu_arb_ctrl: directed scenarios plus a randomized run against a behavioural model.
// A second instance with ISSUE_WAIT=4 is used for the reset-during-issue scenario.
module tb_fpu_arb_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid, req1_valid, resp0_ready, resp1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [5:0]  req0_func, req1_func;

  logic        req0_ready, req1_ready, resp0_valid, resp1_valid;
  logic        resp0_cond, resp1_cond, resp0_err, resp1_err, fcc;
  logic [31:0] resp0_result, resp1_result, alu_a, alu_b, alu_result;
  logic [5:0]  alu_func;
  logic        alu_eq, alu_lt, alu_gt, alu_le, alu_ge;

  logic        w_req0_ready, w_req1_ready, w_resp0_valid, w_resp1_valid;
  logic        w_resp0_cond, w_resp1_cond, w_resp0_err, w_resp1_err, w_fcc;
  logic [31:0] w_resp0_result, w_resp1_result, w_alu_a, w_alu_b, w_alu_result;
  logic [5:0]  w_alu_func;
  logic        w_alu_eq, w_alu_lt, w_alu_gt, w_alu_le, w_alu_ge;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // ALU stubs: integer add for arithmetic ops, unsigned compares for flags.
  assign alu_result = alu_a + alu_b;
  assign alu_eq = (alu_a == alu_b);
  assign alu_lt = (alu_a <  alu_b);
  assign alu_le = (alu_a <= alu_b);
  assign alu_gt = (alu_a >  alu_b);
  assign alu_ge = (alu_a >= alu_b);
  assign w_alu_result = w_alu_a + w_alu_b;
  assign w_alu_eq = (w_alu_a == w_alu_b);
  assign w_alu_lt = (w_alu_a <  w_alu_b);
  assign w_alu_le = (w_alu_a <= w_alu_b);
  assign w_alu_gt = (w_alu_a >  w_alu_b);
  assign w_alu_ge = (w_alu_a >= w_alu_b);

  fpu_arb_ctrl #(.ISSUE_WAIT(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_func(req0_func),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_func(req1_func),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_result(resp0_result),
    .resp0_cond(resp0_cond), .resp0_err(resp0_err),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_result(resp1_result),
    .resp1_cond(resp1_cond), .resp1_err(resp1_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_result(alu_result),
    .alu_eq(alu_eq), .alu_lt(alu_lt), .alu_gt(alu_gt), .alu_le(alu_le), .alu_ge(alu_ge),
    .fcc(fcc)
  );

  fpu_arb_ctrl #(.ISSUE_WAIT(4)) dut4 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(w_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_func(req0_func),
    .req1_valid(req1_valid), .req1_ready(w_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_func(req1_func),
    .resp0_valid(w_resp0_valid), .resp0_ready(resp0_ready), .resp0_result(w_resp0_result),
    .resp0_cond(w_resp0_cond), .resp0_err(w_resp0_err),
    .resp1_valid(w_resp1_valid), .resp1_ready(resp1_ready), .resp1_result(w_resp1_result),
    .resp1_cond(w_resp1_cond), .resp1_err(w_resp1_err),
    .alu_a(w_alu_a), .alu_b(w_alu_b), .alu_func(w_alu_func), .alu_result(w_alu_result),
    .alu_eq(w_alu_eq), .alu_lt(w_alu_lt), .alu_gt(w_alu_gt), .alu_le(w_alu_le), .alu_ge(w_alu_ge),
    .fcc(w_fcc)
  );

  // Reference behaviour of one operation from its opcode and operands.
  function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic cond, output logic err,
                                inout logic fcc_v);
    res = 32'd0; cond = 1'b0; err = 1'b0;
    if (f == 6'd0 || f == 6'd1 || f == 6'd7) res = a + b;
    else if (f >= 6'd8) err = 1'b1;
    else begin
      case (f)
        6'd2:    cond = (a == b);
        6'd3:    cond = (a <  b);
        6'd4:    cond = (a <= b);
        6'd5:    cond = (a >  b);
        default: cond = (a >= b);
      endcase
      fcc_v = cond;
    end
  endfunction

  task automatic set_req(input int id, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] f);
    if (id == 0) begin req0_valid = v; req0_a = a; req0_b = b; req0_func = f; end
    else begin req1_valid = v; req1_a = a; req1_b = b; req1_func = f; end
  endtask

  task automatic do_reset();
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; resp0_ready = 1'b0; resp1_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue one request from an idle DUT and wait (bounded) for its response.
  task automatic run_req(input int id, input logic [31:0] a, input logic [31:0] b, input logic [5:0] f,
                         output bit got);
    @(negedge clk); set_req(id, 1'b1, a, b, f);
    @(negedge clk); set_req(id, 1'b0, a, b, f);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if ((id == 0) ? resp0_valid : resp1_valid) got = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic ack(input int id);
    if (id == 0) resp0_ready = 1'b1; else resp1_ready = 1'b1;
    @(negedge clk);
    resp0_ready = 1'b0; resp1_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_req(0, 1'b1, 32'h1, 32'h2, 6'd0);
    set_req(1, 1'b1, 32'h3, 32'h4, 6'd0);
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    #2;
    total++; if ({req0_ready, req1_ready, resp0_valid, resp1_valid} !== 4'b0) begin
      bad++; $display("FAIL reset_hs got=%b exp=0000", {req0_ready, req1_ready, resp0_valid, resp1_valid}); end
    total++; if ({alu_a, alu_b, alu_func} !== '0) begin
      bad++; $display("FAIL reset_alu got=%h exp=0", {alu_a, alu_b, alu_func}); end
    total++; if ({resp0_result, resp1_result, resp0_cond, resp1_cond, resp0_err, resp1_err, fcc} !== '0) begin
      bad++; $display("FAIL reset_resp got=%h exp=0",
                      {resp0_result, resp1_result, resp0_cond, resp1_cond, resp0_err, resp1_err, fcc}); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if ({req1_ready, req0_ready} !== 2'b01) begin
      bad++; $display("FAIL first_grant got=%b exp=01", {req1_ready, req0_ready}); end
    req0_valid = 1'b0; req1_valid = 1'b0; resp0_ready = 1'b0; resp1_ready = 1'b0;
  endtask

  task automatic test_latency();
    do_reset();
    set_req(0, 1'b1, 32'h3F800000, 32'h40000000, 6'd0);
    #1;
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL lat_accept got=%b exp=1", req0_ready); end
    @(negedge clk);
    set_req(0, 1'b0, 32'h0, 32'h0, 6'd0);
    total++; if (resp0_valid !== 1'b0) begin bad++; $display("FAIL lat_early got=%b exp=0", resp0_valid); end
    total++; if ({alu_a, alu_b, alu_func} !== {32'h3F800000, 32'h40000000, 6'd0}) begin
      bad++; $display("FAIL lat_alu got=%h exp=%h", {alu_a, alu_b, alu_func}, {32'h3F800000, 32'h40000000, 6'd0}); end
    @(negedge clk);
    total++; if (resp0_valid !== 1'b1) begin bad++; $display("FAIL lat_valid got=%b exp=1", resp0_valid); end
    total++; if (resp0_result !== 32'h7F800000) begin
      bad++; $display("FAIL lat_result got=%h exp=7f800000", resp0_result); end
    total++; if ({resp0_cond, resp0_err} !== 2'b00) begin
      bad++; $display("FAIL lat_flags got=%b exp=00", {resp0_cond, resp0_err}); end
    ack(0);
    total++; if ({resp0_valid, resp0_result} !== 33'd0) begin
      bad++; $display("FAIL lat_drop got=%h exp=0", {resp0_valid, resp0_result}); end
  endtask

  task automatic test_back_to_back();
    int n, prev;
    logic g;
    do_reset();
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    set_req(0, 1'b1, 32'd1, 32'd2, 6'd0);
    set_req(1, 1'b1, 32'd3, 32'd4, 6'd0);
    n = 0; prev = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (req0_ready || req1_ready) begin
        g = n[0];
        total++; if ({req1_ready, req0_ready} !== (g ? 2'b10 : 2'b01)) begin
          bad++; $display("FAIL b2b_grant%0d got=%b exp=%b", n, {req1_ready, req0_ready}, g ? 2'b10 : 2'b01); end
        if (n > 0) begin
          total++; if (c - prev != 3) begin
            bad++; $display("FAIL b2b_spacing%0d got=%0d exp=3", n, c - prev); end
        end
        prev = c;
        n++;
      end
      @(negedge clk);
    end
    total++; if (n != 10) begin bad++; $display("FAIL b2b_count got=%0d exp=10", n); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) @(negedge clk);
    resp0_ready = 1'b0; resp1_ready = 1'b0;
  endtask

  task automatic test_fcc();
    bit got;
    run_req(1, 32'd1, 32'd2, 6'd3, got);
    total++; if (!got) begin bad++; $display("FAIL fcc_lt_timeout got=0 exp=1"); end
    total++; if ({resp1_cond, fcc, resp1_err} !== 3'b110) begin
      bad++; $display("FAIL fcc_lt got=%b exp=110", {resp1_cond, fcc, resp1_err}); end
    ack(1);
    run_req(1, 32'd5, 32'd6, 6'd0, got);
    total++; if (resp1_result !== 32'd11 || fcc !== 1'b1) begin
      bad++; $display("FAIL fcc_add got=%h/%b exp=b/1", resp1_result, fcc); end
    ack(1);
    run_req(1, 32'd1, 32'd2, 6'd2, got);
    total++; if ({resp1_cond, fcc} !== 2'b00) begin
      bad++; $display("FAIL fcc_eq got=%b exp=00", {resp1_cond, fcc}); end
    ack(1);
  endtask

  task automatic test_err();
    bit got;
    run_req(0, 32'd3, 32'd2, 6'd5, got);
    total++; if (fcc !== 1'b1) begin bad++; $display("FAIL err_setup got=%b exp=1", fcc); end
    ack(0);
    run_req(0, 32'd7, 32'd8, 6'd9, got);
    total++; if (!got) begin bad++; $display("FAIL err_timeout got=0 exp=1"); end
    total++; if ({resp0_err, resp0_cond, resp0_result, fcc} !== {1'b1, 1'b0, 32'd0, 1'b1}) begin
      bad++; $display("FAIL err_resp got=%h exp=%h", {resp0_err, resp0_cond, resp0_result, fcc},
                      {1'b1, 1'b0, 32'd0, 1'b1}); end
    ack(0);
  endtask

  task automatic test_stall();
    bit got;
    @(negedge clk);
    set_req(0, 1'b1, 32'd100, 32'd23, 6'd0);
    @(negedge clk);
    set_req(0, 1'b0, 32'd0, 32'd0, 6'd0);
    set_req(1, 1'b1, 32'd4, 32'd5, 6'd1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (resp0_valid) got = 1'b1; else @(negedge clk);
    end
    total++; if (!got) begin bad++; $display("FAIL stall_timeout got=0 exp=1"); end
    for (int i = 0; i < 5; i++) begin
      total++; if ({resp0_valid, resp0_result, resp0_cond, resp0_err, req1_ready} !== {1'b1, 32'd123, 3'b000}) begin
        bad++; $display("FAIL stall_hold%0d got=%h exp=%h", i,
                        {resp0_valid, resp0_result, resp0_cond, resp0_err, req1_ready}, {1'b1, 32'd123, 3'b000}); end
      @(negedge clk);
    end
    ack(0);
    total++; if ({resp0_valid, req1_ready} !== 2'b01) begin
      bad++; $display("FAIL stall_release got=%b exp=01", {resp0_valid, req1_ready}); end
    @(negedge clk);
    set_req(1, 1'b0, 32'd0, 32'd0, 6'd0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (resp1_valid) got = 1'b1; else @(negedge clk);
    end
    total++; if (!got || resp1_result !== 32'd9) begin
      bad++; $display("FAIL stall_pending got=%b/%h exp=1/9", got, resp1_result); end
    ack(1);
  endtask

  task automatic test_rand();
    logic        last_m, fcc_m, g, ec, ee;
    logic [1:0]  v;
    logic [31:0] a0, b0, a1, b1, ea, eb, er;
    logic [5:0]  f0, f1, ef;
    int          k;
    do_reset();
    last_m = 1'b1;
    fcc_m  = 1'b0;
    for (int it = 0; it < 40; it++) begin
      v  = 2'($urandom_range(1, 3));
      a0 = $urandom; b0 = ($urandom_range(0, 1) != 0) ? a0 : $urandom; f0 = 6'($urandom_range(0, 11));
      a1 = $urandom; b1 = ($urandom_range(0, 1) != 0) ? a1 : $urandom; f1 = 6'($urandom_range(0, 11));
      set_req(0, v[0], a0, b0, f0);
      set_req(1, v[1], a1, b1, f1);
      g = (v == 2'b11) ? !last_m : v[1];
      #1;
      total++; if ({req1_ready, req0_ready} !== (g ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL rand_grant%0d got=%b exp=%b", it, {req1_ready, req0_ready}, g ? 2'b10 : 2'b01); end
      last_m = g;
      ea = g ? a1 : a0; eb = g ? b1 : b0; ef = g ? f1 : f0;
      model(ef, ea, eb, er, ec, ee, fcc_m);
      @(negedge clk);
      set_req(0, 1'($urandom_range(0, 1)), $urandom, $urandom, 6'($urandom_range(0, 11)));
      set_req(1, 1'($urandom_range(0, 1)), $urandom, $urandom, 6'($urandom_range(0, 11)));
      #1;
      total++; if ({req1_ready, req0_ready, alu_a, alu_b, alu_func} !== {2'b00, ea, eb, ef}) begin
        bad++; $display("FAIL rand_issue%0d got=%h exp=%h", it, {req1_ready, req0_ready, alu_a, alu_b, alu_func},
                        {2'b00, ea, eb, ef}); end
      @(negedge clk);
      k = $urandom_range(0, 2);
      for (int j = 0; j <= k; j++) begin
        total++;
        if ({resp1_valid, resp0_valid} !== (g ? 2'b10 : 2'b01) ||
            (g ? resp1_result : resp0_result) !== er || (g ? resp1_cond : resp0_cond) !== ec ||
            (g ? resp1_err : resp0_err) !== ee || fcc !== fcc_m) begin
          bad++;
          $display("FAIL rand_resp%0d got=v%b r%h c%b e%b f%b exp=v%b r%h c%b e%b f%b", it,
                   {resp1_valid, resp0_valid}, g ? resp1_result : resp0_result, g ? resp1_cond : resp0_cond,
                   g ? resp1_err : resp0_err, fcc, g ? 2'b10 : 2'b01, er, ec, ee, fcc_m);
        end
        if (j < k) @(negedge clk);
      end
      ack(int'(g));
      total++; if ({resp1_valid, resp0_valid, resp0_result, resp1_result} !== '0) begin
        bad++; $display("FAIL rand_drop%0d got=%h exp=0", it, {resp1_valid, resp0_valid, resp0_result, resp1_result}); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_mid_issue();
    bit got, seen;
    do_reset();
    set_req(0, 1'b1, 32'd1, 32'd2, 6'd3);
    #1;
    total++; if (w_req0_ready !== 1'b1) begin bad++; $display("FAIL mid_accept got=%b exp=1", w_req0_ready); end
    @(negedge clk);
    set_req(0, 1'b0, 32'd0, 32'd0, 6'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if ({w_resp0_valid, w_fcc, w_alu_a} !== 34'd0) begin
      bad++; $display("FAIL mid_abort got=%h exp=0", {w_resp0_valid, w_fcc, w_alu_a}); end
    @(negedge clk);
    rst = 1'b0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (w_resp0_valid || w_resp1_valid || w_fcc) seen = 1'b1;
      @(negedge clk);
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_quiet got=1 exp=0"); end
    set_req(0, 1'b1, 32'd1, 32'd2, 6'd3);
    set_req(1, 1'b1, 32'd4, 32'd5, 6'd0);
    #1;
    total++; if ({w_req1_ready, w_req0_ready} !== 2'b01) begin
      bad++; $display("FAIL mid_prio got=%b exp=01", {w_req1_ready, w_req0_ready}); end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (w_resp0_valid) got = 1'b1; else @(negedge clk);
    end
    total++; if ({got, w_resp0_cond, w_fcc} !== 3'b111) begin
      bad++; $display("FAIL mid_clean got=%b exp=111", {got, w_resp0_cond, w_fcc}); end
    repeat (3) @(negedge clk);
    resp0_ready = 1'b0; resp1_ready = 1'b0;
  endtask

  initial begin
    req0_valid = 1'b0; req1_valid = 1'b0; resp0_ready = 1'b0; resp1_ready = 1'b0;
    req0_a = '0; req0_b = '0; req0_func = '0; req1_a = '0; req1_b = '0; req1_func = '0;
    #1;
    test_reset();
    test_latency();
    test_back_to_back();
    test_fcc();
    test_err();
    test_stall();
    test_rand();
    test_mid_issue();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
